// File: rtl/fp_pkg.sv
// Shared definitions for the custom-format floating-point adder datapath:
// word field positions, status codes and the adder stage code for "result ready".
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 25;
    localparam int MANT_MSB = 24;

    localparam int WORD_W   = SIGN_BIT + 1;
    localparam int STATUS_W = 4;

    typedef enum logic [1:0] {
        ST_EXACT   = 2'd0,
        ST_OVF     = 2'd1,
        ST_UNF     = 2'd2,
        ST_INEXACT = 2'd3
    } fp_status_t;

    localparam logic [2:0] STAGE_CHECK = 3'd4;

    // Zero of either sign: exponent and stored mantissa both clear.
    function automatic logic is_zero(input logic [WORD_W-1:0] word);
        return (word[EXP_MSB:EXP_LSB] == '0) && (word[MANT_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock show-ahead FIFO. A push into a full FIFO is only accepted
// when a pop happens on the same edge; otherwise the write is ignored.
//
// state   | meaning
// EMPTY   | fill == 0, head is stale
// PARTIAL | 0 < fill < DEPTH
// FULL    | fill == DEPTH, push needs a same-cycle pop
module fp_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clock_100kHz,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PARTIAL = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [1:0]       state;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        state = S_PARTIAL;
        if (fill == '0) begin
            state = S_EMPTY;
        end else if (fill == (AW+1)'(DEPTH)) begin
            state = S_FULL;
        end
    end

    assign empty   = (state == S_EMPTY);
    assign full    = (state == S_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the read port shows zero until the first write.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                fill <= fill + 1'b1;
            end else if (do_pop && !do_push) begin
                fill <= fill - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// Collects each completed adder result into a FIFO for a valid/ready consumer,
// and keeps saturating per-status event counters plus a sticky lost-result flag.
module fp_result_collector
    import fp_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter int         CNT_W     = 8,
    parameter logic [2:0] DONE_CODE = STAGE_CHECK
) (
    input  logic                     clock_100kHz,
    input  logic                     reset,
    input  logic [2:0]               stage_in,
    input  logic [WORD_W-1:0]        data_in,
    input  logic [STATUS_W-1:0]      status_in,
    input  logic                     clr_stats,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WORD_W-1:0]        rd_data,
    output logic [STATUS_W-1:0]      rd_status,
    output logic                     rd_zero,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         cnt_exact,
    output logic [CNT_W-1:0]         cnt_ovf,
    output logic [CNT_W-1:0]         cnt_unf,
    output logic [CNT_W-1:0]         cnt_inexact,
    output logic                     lost
);

    localparam int REC_W = WORD_W + STATUS_W;

    logic [2:0]       prev_stage;
    logic             capture;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [REC_W-1:0] head;
    logic [CNT_W-1:0] cnt [4];
    fp_status_t       code;
    logic             countable;

    assign capture   = (stage_in == DONE_CODE) && (prev_stage != DONE_CODE);
    assign rd_valid  = !empty;
    assign pop       = rd_valid && rd_ready;
    assign drop      = capture && full && !pop;
    assign code      = fp_status_t'(status_in[1:0]);
    assign countable = capture && (status_in[3:2] == 2'b00);

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            prev_stage <= '0;
        end else begin
            prev_stage <= stage_in;
        end
    end

    fp_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .push         (capture),
        .pop          (pop),
        .wr_data      ({data_in, status_in}),
        .head         (head),
        .full         (full),
        .empty        (empty),
        .fill         (fill)
    );

    assign rd_data   = head[REC_W-1:STATUS_W];
    assign rd_status = head[STATUS_W-1:0];
    // Gated by rd_valid so a cleared, empty FIFO does not report a zero result.
    assign rd_zero   = rd_valid && is_zero(rd_data);

    // Dropped captures still count; a coincident clear takes priority.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            lost <= 1'b0;
        end else if (clr_stats) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            lost <= 1'b0;
        end else begin
            if (countable && (cnt[code] != '1)) begin
                cnt[code] <= cnt[code] + 1'b1;
            end
            if (drop) begin
                lost <= 1'b1;
            end
        end
    end

    assign cnt_exact   = cnt[ST_EXACT];
    assign cnt_ovf     = cnt[ST_OVF];
    assign cnt_unf     = cnt[ST_UNF];
    assign cnt_inexact = cnt[ST_INEXACT];

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed and randomized bench for fp_result_collector against a queue-based
// reference model of the capture, FIFO, counter and lost-flag behaviour.
module tb_fp_result_collector;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clock_100kHz = 1'b0;
    logic        reset        = 1'b0;
    logic [2:0]  stage_in     = '0;
    logic [31:0] data_in      = '0;
    logic [3:0]  status_in    = '0;
    logic        clr_stats    = 1'b0;
    logic        rd_ready     = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  rd_status;
    logic        rd_zero;
    logic [2:0]  fill;
    logic [7:0]  cnt_exact;
    logic [7:0]  cnt_ovf;
    logic [7:0]  cnt_unf;
    logic [7:0]  cnt_inexact;
    logic        lost;

    always #5 clock_100kHz = ~clock_100kHz;

    fp_result_collector #(
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .DONE_CODE (3'd4)
    ) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .stage_in     (stage_in),
        .data_in      (data_in),
        .status_in    (status_in),
        .clr_stats    (clr_stats),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_status    (rd_status),
        .rd_zero      (rd_zero),
        .fill         (fill),
        .cnt_exact    (cnt_exact),
        .cnt_ovf      (cnt_ovf),
        .cnt_unf      (cnt_unf),
        .cnt_inexact  (cnt_inexact),
        .lost         (lost)
    );

    // Reference model: records as {data, status} in a queue.
    logic [35:0] mq [$];
    int          m_cnt [4];
    bit          m_lost;
    logic [2:0]  m_prev;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_lost = 0;
        m_prev = '0;
    endtask

    task automatic check_all();
        logic [31:0] d;
        chk("rd_valid", 36'(rd_valid), 36'(mq.size() != 0));
        chk("fill", 36'(fill), 36'(mq.size()));
        if (mq.size() != 0) begin
            d = mq[0][35:4];
            chk("rd_data", 36'(rd_data), 36'(d));
            chk("rd_status", 36'(rd_status), 36'(mq[0][3:0]));
            chk("rd_zero", 36'(rd_zero), 36'(d[30:25] == 0 && d[24:0] == 0));
        end else begin
            chk("rd_zero_empty", 36'(rd_zero), 36'(0));
        end
        chk("cnt_exact", 36'(cnt_exact), 36'(m_cnt[0]));
        chk("cnt_ovf", 36'(cnt_ovf), 36'(m_cnt[1]));
        chk("cnt_unf", 36'(cnt_unf), 36'(m_cnt[2]));
        chk("cnt_inexact", 36'(cnt_inexact), 36'(m_cnt[3]));
        chk("lost", 36'(lost), 36'(m_lost));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, 36'(rd_data), 36'(0));
        chk({tag, "_rd_status"}, 36'(rd_status), 36'(0));
        check_all();
    endtask

    task automatic step(input logic [2:0] st, input logic [31:0] d, input logic [3:0] s,
                        input bit rr, input bit clr);
        bit cap;
        bit pop;
        bit drop;
        stage_in  = st;
        data_in   = d;
        status_in = s;
        rd_ready  = rr;
        clr_stats = clr;
        @(posedge clock_100kHz);
        cap  = (st == 3'd4) && (m_prev != 3'd4);
        pop  = (mq.size() != 0) && rr;
        drop = cap && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (cap && !drop) mq.push_back({d, s});
        if (clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_lost = 0;
        end else begin
            if (cap && s[3:2] == 2'b00 && m_cnt[s[1:0]] < CNT_MAX) m_cnt[s[1:0]]++;
            if (drop) m_lost = 1;
        end
        m_prev = st;
        #1;
        check_all();
    endtask

    task automatic complete(input logic [31:0] d, input logic [3:0] s, input bit rr);
        step(3'd0, $urandom, 4'($urandom), rr, 1'b0);
        step(3'd4, d, s, rr, 1'b0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[30:0] = '0;
        return w;
    endfunction

    initial begin
        logic [3:0] sts [5];
        sts = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clock_100kHz);
        reset = 1'b1;

        // First completion appears at the head one edge after capture.
        step(3'd0, 32'h0, 4'd0, 1'b0, 1'b0);
        step(3'd4, 32'h4200_0000, 4'd0, 1'b0, 1'b0);
        chk("first_data", 36'(rd_data), 36'h4200_0000);
        chk("first_cnt_exact", 36'(cnt_exact), 36'd1);

        // Holding the done code captures only once.
        for (int i = 0; i < 5; i++) step(3'd4, $urandom, 4'($urandom), 1'b0, 1'b0);
        chk("hold_fill", 36'(fill), 36'd1);

        step(3'd0, 32'h0, 4'd0, 1'b1, 1'b1);

        // Overfill: fifth record dropped, lost set.
        for (int i = 0; i < 5; i++) complete(32'h1000_0000 + 32'(i), sts[i], 1'b0);
        chk("ovf_fill", 36'(fill), 36'd4);
        chk("ovf_lost", 36'(lost), 36'd1);
        chk("ovf_cnt_ovf", 36'(cnt_ovf), 36'd2);
        for (int i = 0; i < 4; i++) begin
            chk("drain_status", 36'(rd_status), 36'(sts[i]));
            step(3'd0, 32'h0, 4'd0, 1'b1, 1'b0);
        end
        chk("drained_valid", 36'(rd_valid), 36'd0);
        step(3'd0, 32'h0, 4'd0, 1'b1, 1'b1);

        // Full FIFO with a coincident pop accepts the push.
        for (int i = 0; i < 4; i++) complete(rand_word(), 4'($urandom), 1'b0);
        step(3'd0, 32'h0, 4'd0, 1'b0, 1'b0);
        step(3'd4, 32'hABCD_0123, 4'd2, 1'b1, 1'b0);
        chk("full_pop_lost", 36'(lost), 36'd0);
        chk("full_pop_fill", 36'(fill), 36'd4);
        for (int i = 0; i < 5; i++) step(3'd0, 32'h0, 4'd0, 1'b1, 1'b0);

        // Saturation of the inexact counter, then clear.
        for (int i = 0; i < 260; i++) complete(rand_word(), 4'd3, 1'b1);
        chk("sat_inexact", 36'(cnt_inexact), 36'd255);
        step(3'd0, 32'h0, 4'd0, 1'b1, 1'b1);
        chk("clr_inexact", 36'(cnt_inexact), 36'd0);

        // Asynchronous reset mid-operation.
        complete(32'h3F00_0001, 4'd1, 1'b0);
        complete(32'h3E00_0002, 4'd2, 1'b0);
        stage_in = 3'd0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        @(negedge clock_100kHz);
        @(negedge clock_100kHz);
        reset = 1'b1;
        complete(32'h4080_0000, 4'd0, 1'b0);
        chk("post_reset_fill", 36'(fill), 36'd1);
        chk("post_reset_data", 36'(rd_data), 36'h4080_0000);
        step(3'd0, 32'h0, 4'd0, 1'b1, 1'b0);

        // Randomized traffic: slow consumer first, then fast consumer.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] st;
            bit rr;
            st = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            rr = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(st, rand_word(), 4'($urandom), rr, $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Downstream stage of the custom-format floating-point adder.
  - Operand format: 1 sign bit [31], 6-bit exponent [30:25], 25-bit stored mantissa [24:0].
  - Status codes: 0 exact, 1 overflow, 2 underflow, 3 inexact.
- Detects each completed addition from the adder's stage code and captures the result word and status into a small FIFO.
- Presents captured results to the consumer over a valid/ready handshake.
- Keeps per-status saturating event counters plus a sticky lost-result flag for debug readout.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of each status counter; counters saturate at all-ones.
- DONE_CODE, 3'd4, stage code that marks "result and status valid".

Ports:
- clock_100kHz  input  1  system clock
- reset  input  1  asynchronous, active-low
- stage_in  input  3  adder progress code
- data_in  input  32  adder result word
- status_in  input  4  adder status code
- clr_stats  input  1  synchronous clear of counters and lost flag
- rd_ready  input  1  consumer accepts the head entry
- rd_valid  output  1  head entry available
- rd_data  output  32  head result word
- rd_status  output  4  head status code
- rd_zero  output  1  head result has exponent==0 and mantissa==0
- fill  output  $clog2(DEPTH)+1  current occupancy
- cnt_exact, cnt_ovf, cnt_unf, cnt_inexact  output  CNT_W each  per-code event counters
- lost  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset value of every output is 0. Reset also clears FIFO pointers, the previous stage register (prev_stage = 0), all counters and lost. Reset is asynchronous and may arrive mid-operation; any partial capture is discarded.
- Capture event: asserted in a cycle where stage_in==DONE_CODE and prev_stage!=DONE_CODE.
  - prev_stage is stage_in registered every cycle.
  - Exactly one capture per entry into DONE_CODE; holding DONE_CODE for several cycles captures once.
- On a capture event, {data_in, status_in} is written at the tail on that clock edge; data and status are sampled in the same cycle as the event.
- FIFO states: EMPTY, PARTIAL, FULL, derived from fill.
  - fill increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Push when FULL and no pop in the same cycle: record dropped, lost set to 1, and lost holds until clr_stats or reset.
  - Push when FULL with a simultaneous pop is accepted and no drop occurs.
- Read side (show-ahead):
  - rd_valid = (fill != 0).
  - rd_data, rd_status and rd_zero reflect the head entry combinationally from storage.
  - Pop occurs when rd_valid && rd_ready; the head advances on that edge.
  - rd_ready while empty has no effect.
- Latency: a capture at edge N gives rd_valid=1 after edge N, with the data at the head if the FIFO was empty. There is no bypass when empty.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Counters:
  - On every capture event, including dropped ones, the counter selected by status_in[1:0] increments by 1 if status_in[3:2]==0 and the counter is below its maximum; it then saturates at 2^CNT_W-1.
  - Codes with status_in[3:2]!=0 are captured into the FIFO but not counted.
- clr_stats zeroes counters and lost on the next edge.
  - If clr_stats and a capture event coincide, clr wins for counters; the FIFO push still happens.
  - clr_stats does not touch FIFO contents.

Decomposition:
- Shared package fp_pkg holds:
  - field positions (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=25, MANT_MSB=24);
  - status codes as an enum fp_status_t (ST_EXACT=0, ST_OVF=1, ST_UNF=2, ST_INEXACT=3);
  - the stage code constant STAGE_CHECK=3'd4, the default for DONE_CODE.
- One natural sub-module: fp_sync_fifo, a parameterised width/depth single-clock FIFO with push, pop, full, empty and fill.
- The edge detector and counters stay in the top.

Test Plan:
- Reset then stage_in 0→4 with data_in=32'h4200_0000, status_in=0 -> after one edge rd_valid=1, rd_data=32'h4200_0000, rd_status=0, fill=1, cnt_exact=1.
- Hold stage_in=4 for 5 cycles -> exactly one capture; fill=1 and cnt_exact=1.
- Five completions with statuses 1,2,3,0,1 and rd_ready=0, DEPTH=4 -> fill=4, lost=1, 5th record absent, cnt_ovf=2, cnt_unf=1, cnt_inexact=1, cnt_exact=1.
  - Then rd_ready=1 drains the records in order with statuses 1,2,3,0.
- FIFO full, a capture event coincides with rd_ready=1 -> no drop, lost stays 0, fill stays 4, head advances.
- 260 completions with status 3, reading continuously -> cnt_inexact saturates at 255; then clr_stats=1 for one cycle -> all counters 0 and lost 0.
- Reset asserted while fill=2 -> all outputs 0 immediately (asynchronous); after release the next completion appears as the sole entry.
